// File: rtl/memory_stage_unit.sv
// Memory stage: owns the 16-bit data/stack memory and turns the EX/MEM
// buffer into the registered MEM/WB buffer. 32-bit PC push/pop is split
// into two word accesses, stalling upstream for the first cycle.
module memory_stage_unit #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MR,
  input  logic        MW,
  input  logic        WB,
  input  logic        Stack_PC,
  input  logic        Stack_Flags,
  input  logic        SP,
  input  logic        SPOP,
  input  logic [2:0]  WB_Address,
  input  logic [31:0] Data,
  input  logic [31:0] Address,
  input  logic [2:0]  Final_Flags,
  output logic        Mem_Stall,
  output logic        WB_Out,
  output logic [2:0]  WB_Address_Out,
  output logic [15:0] Data_Out,
  output logic [31:0] PC_Out,
  output logic        PC_Load,
  output logic [2:0]  Flags_From_Memory,
  output logic        MEM_Stack_Flags
);

  typedef enum logic {IDLE, SECOND} state_t;
  typedef enum logic [2:0] {
    OP_PASS, OP_LOAD, OP_STORE, OP_FPUSH, OP_FPOP, OP_PCPUSH, OP_PCPOP
  } op_t;

  state_t state, state_n;
  op_t    op;

  logic [15:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] a_lat;
  logic [ADDR_WIDTH-1:0] a_inc;
  logic [15:0]           low_lat;
  logic                  pop_lat;
  logic [15:0]           rd_word;
  logic [15:0]           rd_hi;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [15:0]           mem_wdata;

  // SP/SPOP are consumed by the execution stage; upper address bits are ignored
  logic unused_bits;
  assign unused_bits = ^{SP, SPOP, Address[31:ADDR_WIDTH]};

  assign addr    = Address[ADDR_WIDTH-1:0];
  assign a_inc   = a_lat + 1'b1;
  assign rd_word = mem[addr];
  assign rd_hi   = mem[a_inc];

  // Classify the incoming EX/MEM op; stack ops first, MW beats MR
  always_comb begin
    op = OP_PASS;
    if (MW && Stack_PC)          op = OP_PCPUSH;
    else if (MR && Stack_PC)     op = OP_PCPOP;
    else if (MW && Stack_Flags)  op = OP_FPUSH;
    else if (MR && Stack_Flags)  op = OP_FPOP;
    else if (MW)                 op = OP_STORE;
    else if (MR)                 op = OP_LOAD;
  end

  // Next state and stall: only the first half of a PC push/pop stalls
  always_comb begin
    state_n   = state;
    Mem_Stall = 1'b0;
    if (state == SECOND) begin
      state_n = IDLE;
    end else if (op == OP_PCPUSH || op == OP_PCPOP) begin
      state_n   = SECOND;
      Mem_Stall = rst;
    end
  end

  // Single write port: high PC word / flags / store data in IDLE, low PC word in SECOND
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = Data[15:0];
    if (state == SECOND) begin
      if (!pop_lat) begin
        mem_we    = 1'b1;
        mem_waddr = a_lat - 1'b1;
        mem_wdata = low_lat;
      end
    end else begin
      case (op)
        OP_PCPUSH: begin mem_we = 1'b1; mem_wdata = Data[31:16]; end
        OP_FPUSH:  begin mem_we = 1'b1; mem_wdata = {13'b0, Final_Flags}; end
        OP_STORE:  mem_we = 1'b1;
        default:   mem_we = 1'b0;
      endcase
    end
  end

  // Memory array write (contents are not reset; no writes while reset is held)
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // State register and registered MEM/WB outputs; pulses default low each edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      a_lat             <= '0;
      low_lat           <= '0;
      pop_lat           <= 1'b0;
      WB_Out            <= 1'b0;
      WB_Address_Out    <= '0;
      Data_Out          <= '0;
      PC_Out            <= '0;
      PC_Load           <= 1'b0;
      Flags_From_Memory <= '0;
      MEM_Stack_Flags   <= 1'b0;
    end else begin
      state           <= state_n;
      WB_Out          <= 1'b0;
      PC_Load         <= 1'b0;
      MEM_Stack_Flags <= 1'b0;
      if (state == SECOND) begin
        if (pop_lat) begin
          PC_Out  <= {rd_hi, low_lat};
          PC_Load <= 1'b1;
        end
      end else begin
        case (op)
          OP_PCPUSH: begin
            a_lat   <= addr;
            low_lat <= Data[15:0];
            pop_lat <= 1'b0;
          end
          OP_PCPOP: begin
            a_lat   <= addr;
            low_lat <= rd_word;
            pop_lat <= 1'b1;
          end
          OP_FPUSH: ;
          OP_FPOP: begin
            Flags_From_Memory <= rd_word[2:0];
            MEM_Stack_Flags   <= 1'b1;
          end
          OP_STORE: begin
            WB_Out         <= WB;
            WB_Address_Out <= WB_Address;
          end
          OP_LOAD: begin
            Data_Out       <= rd_word;
            WB_Out         <= WB;
            WB_Address_Out <= WB_Address;
          end
          default: begin
            Data_Out       <= Data[15:0];
            WB_Out         <= WB;
            WB_Address_Out <= WB_Address;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_unit.sv
// Self-checking bench for memory_stage_unit: directed scenarios plus random
// op sequences compared against a transaction-level memory model.
module tb_memory_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MR, MW, WB, Stack_PC, Stack_Flags, SP, SPOP;
  logic [2:0]  WB_Address;
  logic [31:0] Data, Address;
  logic [2:0]  Final_Flags;
  logic        Mem_Stall, WB_Out, PC_Load, MEM_Stack_Flags;
  logic [2:0]  WB_Address_Out, Flags_From_Memory;
  logic [15:0] Data_Out;
  logic [31:0] PC_Out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [15:0] mm [0:4095];
  logic [31:0] exp_pc;
  logic [2:0]  exp_flags;

  localparam int K_PASS = 0, K_STORE = 1, K_LOAD = 2, K_FPUSH = 3,
                 K_FPOP = 4, K_PCPUSH = 5, K_PCPOP = 6;

  memory_stage_unit #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .MR(MR), .MW(MW), .WB(WB), .Stack_PC(Stack_PC),
    .Stack_Flags(Stack_Flags), .SP(SP), .SPOP(SPOP), .WB_Address(WB_Address),
    .Data(Data), .Address(Address), .Final_Flags(Final_Flags),
    .Mem_Stall(Mem_Stall), .WB_Out(WB_Out), .WB_Address_Out(WB_Address_Out),
    .Data_Out(Data_Out), .PC_Out(PC_Out), .PC_Load(PC_Load),
    .Flags_From_Memory(Flags_From_Memory), .MEM_Stack_Flags(MEM_Stack_Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    MR = 0; MW = 0; WB = 0; Stack_PC = 0; Stack_Flags = 0; SP = 0; SPOP = 0;
    WB_Address = '0; Data = '0; Address = '0; Final_Flags = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"},  32'(Mem_Stall), 0);
    check({tag, "_wb"},     32'(WB_Out), 0);
    check({tag, "_wba"},    32'(WB_Address_Out), 0);
    check({tag, "_data"},   32'(Data_Out), 0);
    check({tag, "_pc"},     PC_Out, 0);
    check({tag, "_pcld"},   32'(PC_Load), 0);
    check({tag, "_flags"},  32'(Flags_From_Memory), 0);
    check({tag, "_msf"},    32'(MEM_Stack_Flags), 0);
  endtask

  // Drive one EX/MEM op (held through the second cycle of PC ops) and check it
  task automatic do_op(input int kind, input logic [11:0] a, input logic [31:0] d,
                       input logic wb, input logic [2:0] wba, input logic [2:0] ff);
    logic [31:0] hi;
    logic [11:0] am1, ap1;
    logic        two;
    hi  = $urandom;
    am1 = a - 12'd1;
    ap1 = a + 12'd1;
    two = (kind == K_PCPUSH) || (kind == K_PCPOP);
    @(negedge clk);
    MW = (kind == K_STORE) || (kind == K_FPUSH) || (kind == K_PCPUSH);
    MR = (kind == K_LOAD) || (kind == K_FPOP) || (kind == K_PCPOP);
    Stack_PC = two;
    Stack_Flags = (kind == K_FPUSH) || (kind == K_FPOP);
    WB = wb; WB_Address = wba; Data = d; Final_Flags = ff;
    Address = {hi[31:12], a};
    #1 check("stall1", 32'(Mem_Stall), 32'(two));
    @(posedge clk); #1;
    if (two) begin
      check("stall2", 32'(Mem_Stall), 0);
      check("wb_mid", 32'(WB_Out), 0);
      check("pcld_mid", 32'(PC_Load), 0);
      @(posedge clk); #1;
    end
    case (kind)
      K_PASS: begin
        check("pass_data", 32'(Data_Out), 32'(d[15:0]));
        check("pass_wb", 32'(WB_Out), 32'(wb));
        check("pass_wba", 32'(WB_Address_Out), 32'(wba));
      end
      K_STORE: begin
        mm[a] = d[15:0];
        check("st_wb", 32'(WB_Out), 32'(wb));
      end
      K_LOAD: begin
        check("ld_data", 32'(Data_Out), 32'(mm[a]));
        check("ld_wb", 32'(WB_Out), 32'(wb));
        check("ld_wba", 32'(WB_Address_Out), 32'(wba));
      end
      K_FPUSH: begin
        mm[a] = {13'b0, ff};
        check("fpush_wb", 32'(WB_Out), 0);
      end
      K_FPOP: begin
        exp_flags = mm[a][2:0];
        check("fpop_wb", 32'(WB_Out), 0);
      end
      K_PCPUSH: begin
        mm[a] = d[31:16];
        mm[am1] = d[15:0];
        check("pcpush_wb", 32'(WB_Out), 0);
      end
      default: begin
        exp_pc = {mm[ap1], mm[a]};
        check("pcpop_wb", 32'(WB_Out), 0);
      end
    endcase
    check("pc_load", 32'(PC_Load), 32'(kind == K_PCPOP));
    check("msf", 32'(MEM_Stack_Flags), 32'(kind == K_FPOP));
    check("pc_out", PC_Out, exp_pc);
    check("flags", 32'(Flags_From_Memory), 32'(exp_flags));
  endtask

  initial begin
    logic [11:0] ra;
    int          sel;
    idle_in();
    rst = 0;
    exp_pc = '0;
    exp_flags = '0;
    #3 check_zero("rst0");
    @(negedge clk) rst = 1;

    // Give every word a known value so random reads are defined
    for (int i = 0; i < 4096; i++) do_op(K_STORE, 12'(i), $urandom, 1'b0, 3'd0, 3'd0);

    // Directed scenarios
    do_op(K_STORE, 12'h010, 32'h0000BEEF, 1'b0, 3'd0, 3'd0);
    do_op(K_LOAD,  12'h010, 32'h0, 1'b1, 3'd5, 3'd0);
    check("dir_ld", 32'(Data_Out), 32'h0000BEEF);
    do_op(K_PCPUSH, 12'hFFF, 32'h0001ABCD, 1'b0, 3'd0, 3'd0);
    do_op(K_LOAD,  12'hFFF, 32'h0, 1'b1, 3'd1, 3'd0);
    check("dir_hi", 32'(Data_Out), 32'h00000001);
    do_op(K_LOAD,  12'hFFE, 32'h0, 1'b1, 3'd2, 3'd0);
    check("dir_lo", 32'(Data_Out), 32'h0000ABCD);
    do_op(K_PCPOP, 12'hFFE, 32'h0, 1'b0, 3'd0, 3'd0);
    check("dir_pc", PC_Out, 32'h0001ABCD);
    do_op(K_FPUSH, 12'h800, 32'h0, 1'b0, 3'd0, 3'b101);
    do_op(K_FPOP,  12'h800, 32'h0, 1'b0, 3'd0, 3'd0);
    check("dir_flags", 32'(Flags_From_Memory), 32'h5);
    do_op(K_PASS,  12'h000, 32'h0000FFFF, 1'b1, 3'd7, 3'd0);
    do_op(K_PCPUSH, 12'h000, 32'h12345678, 1'b0, 3'd0, 3'd0);
    do_op(K_PCPOP, 12'hFFF, 32'h0, 1'b0, 3'd0, 3'd0);
    check("wrap_pc", PC_Out, 32'h12345678);

    // Asynchronous reset mid-run, then a pass-through
    @(negedge clk);
    idle_in();
    #2 rst = 0;
    #1 check_zero("rst_mid");
    exp_pc = '0;
    exp_flags = '0;
    @(negedge clk) rst = 1;
    do_op(K_PASS, 12'h000, 32'h00001234, 1'b1, 3'd3, 3'd0);
    check("rst_pass", 32'(Data_Out), 32'h00001234);

    // Random op sequences against the model
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      ra = (sel == 0) ? 12'h000 : (sel == 1) ? 12'hFFF : 12'($urandom);
      do_op($urandom_range(0, 6), ra, $urandom, 1'($urandom), 3'($urandom), 3'($urandom));
    end

    // Reset during the second cycle of a PC pop
    @(negedge clk);
    MR = 1; Stack_PC = 1; Address = 32'h00000FFE;
    @(posedge clk);
    #2 rst = 0;
    #1 check_zero("rst_sec");
    exp_pc = '0;
    exp_flags = '0;
    @(negedge clk) idle_in();
    @(posedge clk); #1 check("rst_sec_pcld1", 32'(PC_Load), 0);
    @(negedge clk) rst = 1;
    @(posedge clk); #1 check("rst_sec_pcld2", 32'(PC_Load), 0);
    check("rst_sec_stall", 32'(Mem_Stall), 0);
    do_op(K_PCPUSH, 12'h456, 32'hCAFEF00D, 1'b0, 3'd0, 3'd0);
    do_op(K_PCPOP,  12'h455, 32'h0, 1'b0, 3'd0, 3'd0);
    check("post_rst_pc", PC_Out, 32'hCAFEF00D);
    do_op(K_PASS, 12'h000, 32'h0, 1'b0, 3'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
